regfile_wb_scheduler: RTL and testbench
=======================================

// Module: regfile_wb_scheduler
// PURPOSE
//  Writeback scheduler for the register file's single write port. Arbitrates ALU and load-unit results
//  (round-robin, valid/ready), registers the winner onto the rf write port, and keeps a per-register
//  pending-load scoreboard that reports read hazards to decode. Sits between the execute/mem stages
//  and register_file.
// PARAMETERS
//  REG_COUNT        32  architectural registers; x0 hardwired zero
//  DATA_W           32  write data width (word_t)
//  MAX_OUTSTANDING   4  max in-flight loads; sizes the outstanding counter ($clog2(MAX_OUTSTANDING+1) bits)
// PORTS
//  CLK            in   1       clock; all state updates on posedge CLK
//  nRST           in   1       reset, synchronous, active-low
//  alu_valid      in   1       ALU result available
//  alu_idx        in   5       ALU destination register
//  alu_data       in   DATA_W  ALU result
//  alu_ready      out  1       ALU result accepted this cycle
//  ld_valid       in   1       load result available
//  ld_idx         in   5       load destination register
//  ld_data        in   DATA_W  load data
//  ld_ready       out  1       load result accepted this cycle
//  issue_valid    in   1       decode issues a load
//  issue_idx      in   5       destination of the issued load
//  issue_ready    out  1       scheduler can accept another load
//  rs1_idx        in   5       decode source index 1
//  rs2_idx        in   5       decode source index 2
//  rs1_busy       out  1       rs1 has a write not yet visible in the rf
//  rs2_busy       out  1       rs2 has a write not yet visible in the rf
//  rf_reg_write   out  1       to register file: write enable
//  rf_write_index out  5       to register file: write index
//  rf_write_data  out  DATA_W  to register file: write data
//  ld_underflow   out  1       sticky error: load writeback with zero outstanding
// BEHAVIOUR
//  Reset (nRST low at posedge): rf_reg_write=0, rf_write_index=0, rf_write_data=0, pending[*]=0,
//   outstanding=0, ld_underflow=0, last_grant=LD (ALU wins first tie). Reset mid-operation drops the
//   output stage and all pending state; no rf write occurs in the cycle after reset.
//  Arbitration (comb): one valid -> grant it; both valid -> grant requester != last_grant; none -> none.
//   alu_ready/ld_ready = grant (one-hot or zero). Handshake = valid & ready. last_grant updates only on a
//   handshake. The rf port never back-pressures, so the grant is never withheld when any valid is high.
//  Output stage: handshake in cycle N -> rf_reg_write=1 with the winner's idx/data in cycle N+1 (1-cycle
//   latency); no handshake -> rf_reg_write=0 in N+1. Winner idx==0: handshake completes, rf_reg_write
//   stays 0.
//  Issue: issue_ready = (outstanding < MAX_OUTSTANDING). Issue accept: outstanding+1; pending[issue_idx]
//   set unless idx==0. Load handshake: outstanding-1 (saturates at 0 and sets ld_underflow);
//   pending[ld_idx] cleared. Same-cycle accept + load handshake: outstanding unchanged; same index ->
//   set wins (pending stays 1).
//  Hazard: rsN_busy = (rsN_idx!=0) & (pending[rsN_idx] | (rf_reg_write & rf_write_index==rsN_idx)).
//   Combinational from registered state only; no input->output path except through the index lookups.
// STRUCTURE
//  cpu_types_pkg: word_t, regidx_t (logic [4:0]), REG_COUNT, wb_src_t enum {WB_ALU, WB_LD}.
//  Sub-module wb_rr_arbiter: 2-way round-robin with last_grant flop. Instantiated once. Scoreboard,
//  counter, and output stage stay in this module.
// TESTING
//  1. Reset, then alu_valid=1, idx=3, data=0xDEADBEEF -> alu_ready=1 same cycle; next cycle
//     rf_reg_write=1, index=3, data=0xDEADBEEF.
//  2. Both valid for 4 cycles from reset (ALU idx1, LD idx2) -> grants ALU,LD,ALU,LD;
//     rf_reg_write never drops.
//  3. Issue loads to 5,6,7,8 -> issue_ready=0 after 4th; rs1_idx=6 -> rs1_busy=1; LD writeback
//     idx 6 -> busy=1 the next cycle (output stage), 0 the cycle after; issue_ready=1 again.
//  4. Same cycle: issue idx 9 and LD handshake idx 9 (with 9 pending) -> pending[9]=1, outstanding
//     unchanged.
//  5. ALU writes idx 0 and issue to idx 0 -> handshake occurs, rf_reg_write=0, rs1_idx=0 -> busy=0.
//  6. LD handshake with outstanding=0 -> outstanding=0, ld_underflow=1 until reset. nRST low mid-load
//     -> all outputs return to reset values.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types used by the writeback scheduler and its arbiter.
package cpu_types_pkg;

  localparam int REG_COUNT = 32;
  localparam int DATA_W    = 32;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [4:0]        regidx_t;

  // Which requester owns the register-file write port.
  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LD  = 1'b1
  } wb_src_t;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way round-robin arbiter between ALU and load-unit writeback requests.
// The rf write port never stalls, so a grant always completes a handshake.
module wb_rr_arbiter
  import cpu_types_pkg::*;
(
  input  logic CLK,
  input  logic nRST,
  input  logic alu_valid_i,
  input  logic ld_valid_i,
  output logic grant_alu_o,
  output logic grant_ld_o
);

  wb_src_t last_grant_q;

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    grant_alu_o = 1'b0;
    grant_ld_o  = 1'b0;
    if (alu_valid_i && ld_valid_i) begin
      if (last_grant_q == WB_LD) begin
        grant_alu_o = 1'b1;
      end else begin
        grant_ld_o = 1'b1;
      end
    end else if (alu_valid_i) begin
      grant_alu_o = 1'b1;
    end else if (ld_valid_i) begin
      grant_ld_o = 1'b1;
    end
  end

  // Remember the last winner; reset favours the ALU on the first tie.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      last_grant_q <= WB_LD;
    end else if (grant_alu_o) begin
      last_grant_q <= WB_ALU;
    end else if (grant_ld_o) begin
      last_grant_q <= WB_LD;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler for the register file's single write port: arbitrates
// ALU and load results, registers the winner onto the rf port, and tracks
// in-flight loads so decode can see read-after-write hazards.
module regfile_wb_scheduler
  import cpu_types_pkg::*;
#(
  parameter int REG_COUNT       = cpu_types_pkg::REG_COUNT,
  parameter int DATA_W          = cpu_types_pkg::DATA_W,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              alu_valid,
  input  regidx_t           alu_idx,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              ld_valid,
  input  regidx_t           ld_idx,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              issue_valid,
  input  regidx_t           issue_idx,
  output logic              issue_ready,
  input  regidx_t           rs1_idx,
  input  regidx_t           rs2_idx,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rf_reg_write,
  output regidx_t           rf_write_index,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              ld_underflow
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic                 grant_alu;
  logic                 grant_ld;
  logic                 wb_hs;
  logic                 ld_hs;
  logic                 issue_acc;
  regidx_t              win_idx;
  logic [DATA_W-1:0]    win_data;

  logic                 rf_reg_write_q;
  regidx_t              rf_write_index_q;
  logic [DATA_W-1:0]    rf_write_data_q;
  logic [REG_COUNT-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]     outstanding_q, outstanding_d;
  logic                 ld_underflow_q, ld_underflow_d;

  wb_rr_arbiter u_arb (
    .CLK         (CLK),
    .nRST        (nRST),
    .alu_valid_i (alu_valid),
    .ld_valid_i  (ld_valid),
    .grant_alu_o (grant_alu),
    .grant_ld_o  (grant_ld)
  );

  assign alu_ready   = grant_alu;
  assign ld_ready    = grant_ld;
  assign wb_hs       = grant_alu | grant_ld;
  assign ld_hs       = ld_valid & grant_ld;
  assign issue_ready = (outstanding_q < MAX_CNT);
  assign issue_acc   = issue_valid & issue_ready;
  assign win_idx     = grant_ld ? ld_idx : alu_idx;
  assign win_data    = grant_ld ? ld_data : alu_data;

  // Next-state for the load counter, pending scoreboard and underflow flag;
  // a simultaneous issue to the same register re-arms its pending bit.
  always_comb begin
    pending_d      = pending_q;
    outstanding_d  = outstanding_q;
    ld_underflow_d = ld_underflow_q;
    if (ld_hs) begin
      pending_d[ld_idx] = 1'b0;
    end
    if (issue_acc && (issue_idx != '0)) begin
      pending_d[issue_idx] = 1'b1;
    end
    if (issue_acc && !ld_hs) begin
      outstanding_d = outstanding_q + CNT_W'(1);
    end else if (!issue_acc && ld_hs) begin
      if (outstanding_q == '0) begin
        ld_underflow_d = 1'b1;
      end else begin
        outstanding_d = outstanding_q - CNT_W'(1);
      end
    end
  end

  // Register the arbitration winner onto the rf port and update load tracking.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rf_reg_write_q   <= 1'b0;
      rf_write_index_q <= '0;
      rf_write_data_q  <= '0;
      pending_q        <= '0;
      outstanding_q    <= '0;
      ld_underflow_q   <= 1'b0;
    end else begin
      rf_reg_write_q <= wb_hs && (win_idx != '0);
      if (wb_hs) begin
        rf_write_index_q <= win_idx;
        rf_write_data_q  <= win_data;
      end
      pending_q      <= pending_d;
      outstanding_q  <= outstanding_d;
      ld_underflow_q <= ld_underflow_d;
    end
  end

  assign rf_reg_write   = rf_reg_write_q;
  assign rf_write_index = rf_write_index_q;
  assign rf_write_data  = rf_write_data_q;
  assign ld_underflow   = ld_underflow_q;

  // A source is busy while its load is outstanding or while its value is
  // still sitting in the output stage, not yet written into the rf.
  always_comb begin
    rs1_busy = (rs1_idx != '0) &&
               (pending_q[rs1_idx] || (rf_reg_write_q && (rf_write_index_q == rs1_idx)));
    rs2_busy = (rs2_idx != '0) &&
               (pending_q[rs2_idx] || (rf_reg_write_q && (rf_write_index_q == rs2_idx)));
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: a table of single-cycle
// vectors followed by hand-written multi-cycle sequences.
module tb_regfile_wb_scheduler;

  logic        CLK;
  logic        nRST;
  logic        alu_valid;
  logic [4:0]  alu_idx;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_valid;
  logic [4:0]  ld_idx;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        issue_valid;
  logic [4:0]  issue_idx;
  logic        issue_ready;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        rf_reg_write;
  logic [4:0]  rf_write_index;
  logic [31:0] rf_write_data;
  logic        ld_underflow;

  int total = 0;
  int bad   = 0;

  regfile_wb_scheduler dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .alu_valid      (alu_valid),
    .alu_idx        (alu_idx),
    .alu_data       (alu_data),
    .alu_ready      (alu_ready),
    .ld_valid       (ld_valid),
    .ld_idx         (ld_idx),
    .ld_data        (ld_data),
    .ld_ready       (ld_ready),
    .issue_valid    (issue_valid),
    .issue_idx      (issue_idx),
    .issue_ready    (issue_ready),
    .rs1_idx        (rs1_idx),
    .rs2_idx        (rs2_idx),
    .rs1_busy       (rs1_busy),
    .rs2_busy       (rs2_busy),
    .rf_reg_write   (rf_reg_write),
    .rf_write_index (rf_write_index),
    .rf_write_data  (rf_write_data),
    .ld_underflow   (ld_underflow)
  );

  // Free-running clock, posedge at 5, 15, 25, ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // One cycle of stimulus plus the values expected before and after the edge.
  typedef struct {
    logic        rstN;
    logic        aV;
    logic [4:0]  aIdx;
    logic [31:0] aData;
    logic        lV;
    logic [4:0]  lIdx;
    logic [31:0] lData;
    logic        iV;
    logic [4:0]  iIdx;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        eAR;
    logic        eLR;
    logic        eIR;
    logic        eB1;
    logic        eB2;
    logic        eWr;
    logic        chkWb;
    logic [4:0]  eWIdx;
    logic [31:0] eWData;
    logic        eUf;
  } vec_t;

  vec_t tbl[10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive all inputs at the falling edge so they are stable for the next posedge.
  task automatic drive(input logic rst, input logic aV, input logic [4:0] aIdx, input logic [31:0] aData,
                       input logic lV, input logic [4:0] lIdx, input logic [31:0] lData,
                       input logic iV, input logic [4:0] iIdx, input logic [4:0] r1, input logic [4:0] r2);
    @(negedge CLK);
    nRST        = rst;
    alu_valid   = aV;
    alu_idx     = aIdx;
    alu_data    = aData;
    ld_valid    = lV;
    ld_idx      = lIdx;
    ld_data     = lData;
    issue_valid = iV;
    issue_idx   = iIdx;
    rs1_idx     = r1;
    rs2_idx     = r2;
  endtask

  task automatic applyStimulus(input vec_t v);
    drive(v.rstN, v.aV, v.aIdx, v.aData, v.lV, v.lIdx, v.lData, v.iV, v.iIdx, v.rs1, v.rs2);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Field order: rstN, aV,aIdx,aData, lV,lIdx,lData, iV,iIdx, rs1,rs2,
  //              eAR,eLR,eIR, eB1,eB2, eWr,chkWb,eWIdx,eWData, eUf
  initial begin
    tbl[0] = '{0, 0,0,32'h0,        0,0,32'h0,  0,0, 0,0, 0,0,1, 0,0, 0,1,0,32'h0,        0};
    tbl[1] = '{1, 1,3,32'hDEADBEEF, 0,0,32'h0,  0,0, 0,0, 1,0,1, 0,0, 1,1,3,32'hDEADBEEF, 0};
    tbl[2] = '{0, 0,0,32'h0,        0,0,32'h0,  0,0, 3,0, 0,0,1, 1,0, 0,1,0,32'h0,        0};
    tbl[3] = '{1, 1,1,32'h11,       1,2,32'h22, 0,0, 0,0, 1,0,1, 0,0, 1,1,1,32'h11,       0};
    tbl[4] = '{1, 1,1,32'h11,       1,2,32'h22, 0,0, 0,0, 0,1,1, 0,0, 1,1,2,32'h22,       1};
    tbl[5] = '{1, 1,1,32'h11,       1,2,32'h22, 0,0, 2,1, 1,0,1, 1,0, 1,1,1,32'h11,       1};
    tbl[6] = '{1, 1,1,32'h11,       1,2,32'h22, 0,0, 0,0, 0,1,1, 0,0, 1,1,2,32'h22,       1};
    tbl[7] = '{0, 0,0,32'h0,        0,0,32'h0,  0,0, 0,0, 0,0,1, 0,0, 0,1,0,32'h0,        0};
    tbl[8] = '{1, 1,0,32'h55,       0,0,32'h0,  1,0, 0,0, 1,0,1, 0,0, 0,0,0,32'h0,        0};
    tbl[9] = '{1, 0,0,32'h0,        0,0,32'h0,  0,0, 0,5, 0,0,1, 0,0, 0,0,0,32'h0,        0};

    // Initial reset so the table starts from known state.
    drive(0, 0,0,0, 0,0,0, 0,0, 0,0);
    tick();
    drive(0, 0,0,0, 0,0,0, 0,0, 0,0);
    tick();

    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i]);
      #1;
      checkOutput($sformatf("v%0d alu_ready", i),   32'(alu_ready),   32'(tbl[i].eAR));
      checkOutput($sformatf("v%0d ld_ready", i),    32'(ld_ready),    32'(tbl[i].eLR));
      checkOutput($sformatf("v%0d issue_ready", i), 32'(issue_ready), 32'(tbl[i].eIR));
      checkOutput($sformatf("v%0d rs1_busy", i),    32'(rs1_busy),    32'(tbl[i].eB1));
      checkOutput($sformatf("v%0d rs2_busy", i),    32'(rs2_busy),    32'(tbl[i].eB2));
      tick();
      checkOutput($sformatf("v%0d rf_reg_write", i), 32'(rf_reg_write), 32'(tbl[i].eWr));
      checkOutput($sformatf("v%0d ld_underflow", i), 32'(ld_underflow), 32'(tbl[i].eUf));
      if (tbl[i].chkWb) begin
        checkOutput($sformatf("v%0d rf_write_index", i), 32'(rf_write_index), 32'(tbl[i].eWIdx));
        checkOutput($sformatf("v%0d rf_write_data", i),  rf_write_data,       tbl[i].eWData);
      end
    end

    // Fill the load window with 5,6,7,8 and watch register 6 drain.
    drive(0, 0,0,0, 0,0,0, 0,0, 0,0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1, 0,0,0, 0,0,0, 1,5'(5 + k), 0,0);
      #1;
      checkOutput($sformatf("fill%0d issue_ready", k), 32'(issue_ready), 32'd1);
      tick();
    end
    drive(1, 0,0,0, 0,0,0, 0,0, 6,0);
    #1;
    checkOutput("full issue_ready", 32'(issue_ready), 32'd0);
    checkOutput("full rs1_busy6",   32'(rs1_busy),    32'd1);
    tick();
    drive(1, 0,0,0, 1,6,32'h66, 0,0, 6,0);
    #1;
    checkOutput("ld6 ld_ready", 32'(ld_ready), 32'd1);
    tick();
    checkOutput("ld6 rf_reg_write",   32'(rf_reg_write),   32'd1);
    checkOutput("ld6 rf_write_index", 32'(rf_write_index), 32'd6);
    checkOutput("ld6 rf_write_data",  rf_write_data,       32'h66);
    checkOutput("ld6 rs1_busy stage", 32'(rs1_busy),       32'd1);
    checkOutput("ld6 issue_ready",    32'(issue_ready),    32'd1);
    drive(1, 0,0,0, 0,0,0, 0,0, 6,0);
    tick();
    checkOutput("ld6 rs1_busy clear", 32'(rs1_busy),     32'd0);
    checkOutput("ld6 idle write",     32'(rf_reg_write), 32'd0);

    // Same-cycle issue and load writeback to register 9: set must win.
    drive(1, 0,0,0, 0,0,0, 1,9, 0,0);
    tick();
    drive(1, 0,0,0, 1,8,32'h88, 0,0, 0,0);
    tick();
    drive(1, 0,0,0, 1,9,32'h99, 1,9, 9,0);
    #1;
    checkOutput("same9 issue_ready", 32'(issue_ready), 32'd1);
    checkOutput("same9 ld_ready",    32'(ld_ready),    32'd1);
    checkOutput("same9 rs1_busy",    32'(rs1_busy),    32'd1);
    tick();
    checkOutput("same9 rf_write_index", 32'(rf_write_index), 32'd9);
    drive(1, 0,0,0, 0,0,0, 0,0, 9,8);
    tick();
    checkOutput("same9 pending kept", 32'(rs1_busy),    32'd1);
    checkOutput("same9 rs2_busy8",    32'(rs2_busy),    32'd0);
    checkOutput("same9 count held",   32'(issue_ready), 32'd1);
    drive(1, 0,0,0, 0,0,0, 1,10, 0,0);
    tick();
    checkOutput("refill issue_ready", 32'(issue_ready),  32'd0);
    checkOutput("refill no underflow", 32'(ld_underflow), 32'd0);

    // Underflow is sticky until reset; reset during a load clears everything.
    drive(0, 0,0,0, 0,0,0, 0,0, 0,0);
    tick();
    drive(1, 0,0,0, 1,4,32'h44, 0,0, 0,0);
    tick();
    checkOutput("uf set",          32'(ld_underflow),   32'd1);
    checkOutput("uf write index",  32'(rf_write_index), 32'd4);
    drive(1, 0,0,0, 0,0,0, 0,0, 0,0);
    tick();
    checkOutput("uf sticky",       32'(ld_underflow), 32'd1);
    checkOutput("uf idle write",   32'(rf_reg_write), 32'd0);
    drive(0, 0,0,0, 1,4,32'h44, 0,0, 0,0);
    tick();
    checkOutput("rst rf_reg_write",   32'(rf_reg_write),   32'd0);
    checkOutput("rst rf_write_index", 32'(rf_write_index), 32'd0);
    checkOutput("rst rf_write_data",  rf_write_data,       32'd0);
    checkOutput("rst ld_underflow",   32'(ld_underflow),   32'd0);
    drive(1, 0,0,0, 0,0,0, 0,0, 4,0);
    #1;
    checkOutput("rst issue_ready", 32'(issue_ready), 32'd1);
    checkOutput("rst rs1_busy4",   32'(rs1_busy),    32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
